// File: rtl/stepper_move_ctrl.sv
// Counted-move stepper controller for a 4-coil driver: start/busy/done handshake, wave/full/half drive.
// Optional STEP_POS_EN macro enables the signed half-step position counter; otherwise position is 0.
module stepper_move_ctrl #(
   parameter int PERIOD_W = 24,
   parameter int STEPS_W  = 16,
   parameter int POS_W    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    cmd_dir,
   input  logic [1:0]              cmd_mode,
   input  logic [STEPS_W-1:0]      cmd_steps,
   input  logic [PERIOD_W-1:0]     cmd_period,
   output logic [3:0]              coil,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic signed [POS_W-1:0] position,
   input  logic                    pos_clr
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state, state_nxt;
   logic [2:0]          idx, idx_nxt, idx_step;
   logic [PERIOD_W-1:0] tick, tick_nxt, period_m1;
   logic [STEPS_W-1:0]  remaining, rem_nxt;
   logic                dir_q;
   logic [1:0]          mode_q;
   logic [1:0]          delta;
   logic                load, step, done_nxt, abort_nxt;

   function automatic logic [3:0] phase(input logic [2:0] i);
      case (i)
         3'd0: phase = 4'b1000;
         3'd1: phase = 4'b1100;
         3'd2: phase = 4'b0100;
         3'd3: phase = 4'b0110;
         3'd4: phase = 4'b0010;
         3'd5: phase = 4'b0011;
         3'd6: phase = 4'b0001;
         3'd7: phase = 4'b1001;
      endcase
   endfunction

   // Wave targets even indices, full targets odd; a misaligned index takes a single half-step first.
   assign delta    = (!mode_q[1] && (idx[0] == mode_q[0])) ? 2'd2 : 2'd1;
   assign idx_step = dir_q ? idx + {1'b0, delta} : idx - {1'b0, delta};
   assign busy     = (state == RUN);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      tick_nxt  = tick;
      rem_nxt   = remaining;
      done_nxt  = 1'b0;
      abort_nxt = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (start && en && !stop) begin
               if (cmd_steps == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  load      = 1'b1;
                  state_nxt = RUN;
                  tick_nxt  = '0;
                  rem_nxt   = cmd_steps;
               end
            end
         end
         RUN: begin
            if (stop || !en) begin
               state_nxt = IDLE;
               abort_nxt = 1'b1;
               rem_nxt   = '0;
               tick_nxt  = '0;
            end else if (tick == period_m1) begin
               step     = 1'b1;
               idx_nxt  = idx_step;
               tick_nxt = '0;
               if (remaining != '0) rem_nxt = remaining - 1'b1;
               if (remaining <= 1) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end else begin
               tick_nxt = tick + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         tick      <= '0;
         remaining <= '0;
         period_m1 <= '0;
         dir_q     <= 1'b0;
         mode_q    <= 2'b00;
         done      <= 1'b0;
         aborted   <= 1'b0;
         coil      <= 4'b0000;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         tick      <= tick_nxt;
         remaining <= rem_nxt;
         done      <= done_nxt;
         aborted   <= abort_nxt;
         coil      <= en ? phase(idx) : 4'b0000;
         if (load) begin
            dir_q     <= cmd_dir;
            mode_q    <= cmd_mode;
            // A zero period runs at one step per clock.
            period_m1 <= (cmd_period == '0) ? '0 : cmd_period - 1'b1;
         end
      end
   end

`ifdef STEP_POS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          position <= '0;
      else if (pos_clr) position <= '0;
      else if (step)
         position <= dir_q ? position + {{(POS_W-2){1'b0}}, delta}
                           : position - {{(POS_W-2){1'b0}}, delta};
   end
`else
   logic unused_pos;
   assign unused_pos = pos_clr ^ step;
   assign position   = '0;
`endif

endmodule
